// File: rtl/sd_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_ctrl
// Purpose  : SD-card SPI-mode command sequencer. Frames a 6-byte command,
//            drives it byte-by-byte to the SPI byte engine, polls with 0xFF
//            until an R1 byte or NCR_MAX polls, then sends one trailing 0xFF.
//            Owns the card chip select.
// Revision : 1.0  initial release
// ============================================================================
module sd_cmd_ctrl #(
    parameter int NCR_MAX = 8,      // 1..255 poll bytes before timeout
    parameter bit CRC_EN  = 1'b1    // 0: byte 5 is a fixed 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic        cs_n,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND       = 3'd1,
        ST_WAIT_CMD   = 3'd2,
        ST_POLL       = 3'd3,
        ST_WAIT_POLL  = 3'd4,
        ST_TRAIL      = 3'd5,
        ST_WAIT_TRAIL = 3'd6,
        ST_RESP       = 3'd7
    } state_t;

    localparam logic [7:0] c_POLL_LAST = 8'(NCR_MAX - 1);
    localparam logic [2:0] c_LAST_BYTE = 3'd5;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_poll_cnt;
    logic        r_cs_n;
    logic        r_xfer_start;
    logic [7:0]  r_xfer_tx;
    logic        r_resp_valid;
    logic [7:0]  r_resp_r1;
    logic        r_resp_timeout;

    logic [7:0]  w_crc_byte;
    logic [7:0]  w_frame_byte;

    // CRC7 (x^7 + x^3 + 1), init 0, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    generate
        if (CRC_EN) begin : g_crc
            assign w_crc_byte = {crc7({2'b01, r_idx, r_arg}), 1'b1};
        end else begin : g_no_crc
            assign w_crc_byte = 8'h01;
        end
    endgenerate

    // Select the frame byte addressed by the byte counter
    always_comb begin
        w_frame_byte = w_crc_byte;
        case (r_byte_cnt)
            3'd0:    w_frame_byte = {2'b01, r_idx};
            3'd1:    w_frame_byte = r_arg[31:24];
            3'd2:    w_frame_byte = r_arg[23:16];
            3'd3:    w_frame_byte = r_arg[15:8];
            3'd4:    w_frame_byte = r_arg[7:0];
            default: w_frame_byte = w_crc_byte;
        endcase
    end

    // Command sequencer; all outputs registered, start/valid are single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= 6'd0;
            r_arg          <= 32'd0;
            r_byte_cnt     <= 3'd0;
            r_poll_cnt     <= 8'd0;
            r_cs_n         <= 1'b1;
            r_xfer_start   <= 1'b0;
            r_xfer_tx      <= 8'hFF;
            r_resp_valid   <= 1'b0;
            r_resp_r1      <= 8'hFF;
            r_resp_timeout <= 1'b0;
        end else begin
            r_xfer_start <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_idx      <= cmd_index;
                        r_arg      <= cmd_arg;
                        r_cs_n     <= 1'b0;
                        r_byte_cnt <= 3'd0;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_xfer_start <= 1'b1;
                    r_xfer_tx    <= w_frame_byte;
                    r_state      <= ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    if (xfer_done) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_poll_cnt <= 8'd0;
                            r_state    <= ST_POLL;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                ST_POLL: begin
                    r_xfer_start <= 1'b1;
                    r_xfer_tx    <= 8'hFF;
                    r_state      <= ST_WAIT_POLL;
                end
                ST_WAIT_POLL: begin
                    if (xfer_done) begin
                        // a response wins over timeout on the last poll byte
                        if (!xfer_rx[7]) begin
                            r_resp_r1      <= xfer_rx;
                            r_resp_timeout <= 1'b0;
                            r_state        <= ST_TRAIL;
                        end else if (r_poll_cnt == c_POLL_LAST) begin
                            r_resp_r1      <= 8'hFF;
                            r_resp_timeout <= 1'b1;
                            r_state        <= ST_TRAIL;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 8'd1;
                            r_state    <= ST_POLL;
                        end
                    end
                end
                ST_TRAIL: begin
                    r_xfer_start <= 1'b1;
                    r_xfer_tx    <= 8'hFF;
                    r_state      <= ST_WAIT_TRAIL;
                end
                ST_WAIT_TRAIL: begin
                    if (xfer_done) begin
                        r_cs_n       <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                // resp_valid cycle; ready returns on the following cycle
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign cs_n         = r_cs_n;
    assign xfer_start   = r_xfer_start;
    assign xfer_tx      = r_xfer_tx;
    assign resp_valid   = r_resp_valid;
    assign resp_r1      = r_resp_r1;
    assign resp_timeout = r_resp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sd_cmd_ctrl
// Purpose  : Directed self-checking bench for sd_cmd_ctrl with a behavioural
//            SPI byte engine (CRC-enabled instance) and an inline engine for
//            the CRC-disabled instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // instance A: NCR_MAX=8, CRC enabled
    logic        cmd_valid, cmd_ready, resp_valid, resp_timeout;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [7:0]  resp_r1, xfer_tx, xfer_rx;
    logic        xfer_start, xfer_done, cs_n, busy;

    // instance B: CRC disabled
    logic        b_cmd_valid, b_cmd_ready, b_resp_valid, b_resp_timeout;
    logic [5:0]  b_cmd_index;
    logic [31:0] b_cmd_arg;
    logic [7:0]  b_resp_r1, b_xfer_tx, b_xfer_rx;
    logic        b_xfer_start, b_xfer_done, b_cs_n, b_busy;

    sd_cmd_ctrl #(.NCR_MAX(8), .CRC_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_timeout(resp_timeout),
        .xfer_start(xfer_start), .xfer_tx(xfer_tx),
        .xfer_done(xfer_done), .xfer_rx(xfer_rx),
        .cs_n(cs_n), .busy(busy)
    );

    sd_cmd_ctrl #(.NCR_MAX(8), .CRC_EN(1'b0)) dut_nocrc (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_index(b_cmd_index), .cmd_arg(b_cmd_arg),
        .resp_valid(b_resp_valid), .resp_r1(b_resp_r1), .resp_timeout(b_resp_timeout),
        .xfer_start(b_xfer_start), .xfer_tx(b_xfer_tx),
        .xfer_done(b_xfer_done), .xfer_rx(b_xfer_rx),
        .cs_n(b_cs_n), .busy(b_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int n_start   = 0;
    int n_resp    = 0;
    int nb_start  = 0;
    always @(negedge clk) begin
        if (xfer_start === 1'b1)   n_start++;
        if (resp_valid === 1'b1)   n_resp++;
        if (b_xfer_start === 1'b1) nb_start++;
    end

    // ---------------- engine model for instance A ----------------
    int         eng_delay = 2;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         xch;

    initial begin
        xfer_done = 1'b0;
        xfer_rx   = 8'h00;
        xch       = 0;
        forever begin
            @(posedge clk); #1;
            if (cs_n === 1'b1) xch = 0;
            if (xfer_start === 1'b1) begin
                tx_log.push_back(xfer_tx);
                repeat (eng_delay) begin @(posedge clk); #1; end
                if (xch >= 6 && rx_q.size() > 0) xfer_rx = rx_q.pop_front();
                else                             xfer_rx = 8'hFF;
                xfer_done = 1'b1;
                xch++;
                @(posedge clk); #1;
                xfer_done = 1'b0;
                xfer_rx   = 8'h00;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_index = 6'h3F;          // scrambled after accept: frame must use latched values
        cmd_arg   = 32'hDEAD_BEEF;
    endtask

    task automatic wait_resp(input string tag);
        int t;
        t = 0;
        while (resp_valid !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        chk({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
        chk({tag, "_cs_at_resp"}, 32'(cs_n), 32'd1);
        chk({tag, "_ready_at_resp"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic check_log(input string tag, input logic [127:0] exp, input int n);
        logic [31:0] got;
        chk({tag, "_len"}, 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hBAD0_0000;
            chk($sformatf("%s_b%0d", tag, i), got, 32'(exp[(n-1-i)*8 +: 8]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          t;
        int          s0;
        int          r0;
        int          bad;
        logic [7:0]  hold;
        logic [63:0] exp6;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_index   = 6'd0;
        cmd_arg     = 32'd0;
        b_cmd_valid = 1'b0;
        b_cmd_index = 6'd0;
        b_cmd_arg   = 32'd0;
        b_xfer_done = 1'b0;
        b_xfer_rx   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_xfer_start", 32'(xfer_start), 32'd0);
        chk("rst_xfer_tx", 32'(xfer_tx), 32'hFF);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_r1", 32'(resp_r1), 32'hFF);
        chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: CMD0, response on second poll; also first-start latency
        tx_log.delete(); rx_q.delete();
        rx_q.push_back(8'hFF); rx_q.push_back(8'h01);
        issue(6'd0, 32'd0);
        chk("t1_cs_after_accept", 32'(cs_n), 32'd0);
        chk("t1_busy_after_accept", 32'(busy), 32'd1);
        chk("t1_no_start_yet", 32'(xfer_start), 32'd0);
        @(posedge clk); #1;
        chk("t1_first_start", 32'(xfer_start), 32'd1);
        wait_resp("t1");
        chk("t1_r1", 32'(resp_r1), 32'h01);
        chk("t1_timeout", 32'(resp_timeout), 32'd0);
        check_log("t1", {48'h40_00_00_00_00_95, 24'hFF_FF_FF}, 9);
        @(posedge clk); #1;
        chk("t1_resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("t1_ready_after", 32'(cmd_ready), 32'd1);

        // T2: CMD8 0x1AA, R1 on first poll
        tx_log.delete(); rx_q.delete();
        rx_q.push_back(8'h05);
        issue(6'd8, 32'h0000_01AA);
        wait_resp("t2");
        chk("t2_r1", 32'(resp_r1), 32'h05);
        chk("t2_timeout", 32'(resp_timeout), 32'd0);
        check_log("t2", {48'h48_00_00_01_AA_87, 16'hFF_FF}, 8);

        // T3: card never answers -> 8 polls, timeout
        tx_log.delete(); rx_q.delete();
        issue(6'd0, 32'd0);
        wait_resp("t3");
        chk("t3_r1", 32'(resp_r1), 32'hFF);
        chk("t3_timeout", 32'(resp_timeout), 32'd1);
        check_log("t3", {48'h40_00_00_00_00_95, {9{8'hFF}}}, 15);

        // T7: R1 = 8'h00 on the last allowed poll still counts as a response
        tx_log.delete(); rx_q.delete();
        for (int i = 0; i < 7; i++) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h00);
        issue(6'd0, 32'd0);
        wait_resp("t7");
        chk("t7_r1", 32'(resp_r1), 32'h00);
        chk("t7_timeout", 32'(resp_timeout), 32'd0);
        check_log("t7", {48'h40_00_00_00_00_95, {9{8'hFF}}}, 15);

        // T4: cmd_valid held while busy with another command
        @(posedge clk); #1;
        tx_log.delete(); rx_q.delete();
        rx_q.push_back(8'h01);
        cmd_index = 6'd0; cmd_arg = 32'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("t4_accept1", 32'(busy), 32'd1);
        cmd_index = 6'd8; cmd_arg = 32'h0000_01AA;
        wait_resp("t4a");
        chk("t4a_r1", 32'(resp_r1), 32'h01);
        rx_q.push_back(8'h01);
        @(posedge clk); #1;
        chk("t4_ready_rises", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("t4_accept2", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        wait_resp("t4b");
        chk("t4b_r1", 32'(resp_r1), 32'h01);
        check_log("t4", {48'h40_00_00_00_00_95, 16'hFF_FF,
                         48'h48_00_00_01_AA_87, 16'hFF_FF}, 16);

        // T5: reset during third command byte
        @(posedge clk); #1;
        tx_log.delete(); rx_q.delete();
        eng_delay = 3;
        issue(6'd0, 32'd0);
        t = 0;
        while (tx_log.size() < 3 && t < 200) begin @(negedge clk); t++; end
        chk("t5_reached_byte3", 32'(tx_log.size()), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_cs_n", 32'(cs_n), 32'd1);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        chk("t5_resp_valid", 32'(resp_valid), 32'd0);
        s0 = n_start; r0 = n_resp;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_start_after", 32'(n_start - s0), 32'd0);
        chk("t5_no_resp_after", 32'(n_resp - r0), 32'd0);
        chk("t5_still_idle", 32'(cmd_ready), 32'd1);
        chk("t5_tx_idle", 32'(xfer_tx), 32'hFF);
        eng_delay = 2;
        tx_log.delete(); rx_q.delete();
        rx_q.push_back(8'h01);
        issue(6'd0, 32'd0);
        wait_resp("t5");
        chk("t5_r1", 32'(resp_r1), 32'h01);
        check_log("t5", {48'h40_00_00_00_00_95, 16'hFF_FF}, 8);

        // T6: CRC disabled, CMD55, engine takes 40 cycles per byte
        exp6 = 64'h77_00_00_00_00_01_FF_FF;
        bad  = 0;
        s0   = nb_start;
        b_cmd_index = 6'd55; b_cmd_arg = 32'd0; b_cmd_valid = 1'b1;
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (b_xfer_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
            chk($sformatf("t6_start%0d", i), 32'(b_xfer_start), 32'd1);
            chk($sformatf("t6_b%0d", i), 32'(b_xfer_tx), 32'(exp6[(7-i)*8 +: 8]));
            hold = b_xfer_tx;
            repeat (40) begin
                @(posedge clk); #1;
                if (b_xfer_tx !== hold) bad++;
            end
            b_xfer_rx   = (i == 6) ? 8'h01 : 8'hFF;
            b_xfer_done = 1'b1;
            @(posedge clk); #1;
            b_xfer_done = 1'b0;
            b_xfer_rx   = 8'h00;
        end
        chk("t6_resp_valid", 32'(b_resp_valid), 32'd1);
        chk("t6_r1", 32'(b_resp_r1), 32'h01);
        chk("t6_timeout", 32'(b_resp_timeout), 32'd0);
        chk("t6_cs_n", 32'(b_cs_n), 32'd1);
        chk("t6_tx_stable", 32'(bad), 32'd0);
        chk("t6_start_total", 32'(nb_start - s0), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
